// File: rtl/spdif_bmc_stream_encoder.sv
// spdif_bmc_stream_encoder
// Buffers WIDTH-bit words of pre-computed transition bits in a DEPTH-entry
// FIFO and shifts them MSB-first onto q, toggling q on every '1' bit.
// Underruns are handled on whole word slots: q either holds or emits a
// BMC-zero fill, and each empty slot bumps a saturating counter.
module spdif_bmc_stream_encoder #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int START_LEVEL = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                         clk128,
  input  logic                         reset_n,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         fill_en,
  input  logic                         count_clear,
  output logic                         q,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         is_underrun,
  output logic                         word_start,
  output logic [COUNT_WIDTH-1:0]       underrun_count
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0] START_L    = LW'(START_LEVEL);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_t;

  state_t                 state_r;
  logic [WIDTH-1:0]       fifo_mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic [WIDTH-1:0]       shift_r;
  logic [BW-1:0]          bit_cnt_r;
  logic                   q_r;
  logic                   is_underrun_r;
  logic                   word_start_r;
  logic [COUNT_WIDTH-1:0] underrun_count_r;

  logic                   ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   slot_end_s;
  logic                   have_word_s;
  logic                   inc_s;
  logic [WIDTH-1:0]       head_s;

  // Handshake, pop decision and underrun-slot detection from registered state
  always_comb begin
    ready_s     = (level_r < DEPTH_L);
    push_s      = i_valid & ready_s;
    slot_end_s  = (bit_cnt_r == LAST_BIT);
    have_word_s = (level_r != {LW{1'b0}});
    head_s      = fifo_mem_r[rd_ptr_r];
    pop_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pop_s = (level_r >= START_L);
        inc_s = 1'b0;
      end
      ST_RUN, ST_UNDERRUN: begin
        pop_s = slot_end_s & have_word_s;
        inc_s = slot_end_s & ~have_word_s;
      end
      default: begin
        pop_s = 1'b0;
        inc_s = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk128) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers and occupancy; write and pop on one edge cancel out
  always_ff @(posedge clk128) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Serialiser FSM: idle prefill, word shifting, slot-aligned underrun fill
  always_ff @(posedge clk128) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      shift_r       <= {WIDTH{1'b0}};
      bit_cnt_r     <= {BW{1'b0}};
      q_r           <= 1'b0;
      is_underrun_r <= 1'b0;
      word_start_r  <= 1'b0;
    end else begin
      word_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          is_underrun_r <= 1'b0;
          if (pop_s) begin
            shift_r      <= head_s;
            bit_cnt_r    <= {BW{1'b0}};
            word_start_r <= 1'b1;
            state_r      <= ST_RUN;
          end
        end
        ST_RUN: begin
          q_r       <= q_r ^ shift_r[WIDTH-1];
          bit_cnt_r <= bit_cnt_r + BW'(1);
          if (pop_s) begin
            shift_r      <= head_s;
            word_start_r <= 1'b1;
          end else if (slot_end_s) begin
            shift_r       <= shift_r << 1;
            state_r       <= ST_UNDERRUN;
            is_underrun_r <= 1'b1;
          end else begin
            shift_r <= shift_r << 1;
          end
        end
        ST_UNDERRUN: begin
          // fill_en=1 toggles on even bit positions: 1,0,1,0 = BMC zero
          q_r       <= q_r ^ (fill_en & ~bit_cnt_r[0]);
          bit_cnt_r <= bit_cnt_r + BW'(1);
          if (pop_s) begin
            shift_r       <= head_s;
            word_start_r  <= 1'b1;
            state_r       <= ST_RUN;
            is_underrun_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          is_underrun_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of empty word slots; clear wins over increment
  always_ff @(posedge clk128) begin
    if (!reset_n) begin
      underrun_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (count_clear) begin
      underrun_count_r <= {COUNT_WIDTH{1'b0}};
    end else if (inc_s && (underrun_count_r != CNT_MAX)) begin
      underrun_count_r <= underrun_count_r + COUNT_WIDTH'(1);
    end else begin
      underrun_count_r <= underrun_count_r;
    end
  end

  assign i_ready        = ready_s;
  assign q              = q_r;
  assign level          = level_r;
  assign is_underrun    = is_underrun_r;
  assign word_start     = word_start_r;
  assign underrun_count = underrun_count_r;

endmodule

// File: tb/tb_spdif_bmc_stream_encoder.sv
// Directed bench for spdif_bmc_stream_encoder.
// dut_a: START_LEVEL=1, COUNT_WIDTH=2 (latency, fill, hold, saturation, reset)
// dut_b: START_LEVEL=4 (prefill and back-to-back streaming)
module tb_spdif_bmc_stream_encoder;

  logic       clk128 = 1'b0;
  logic       reset_n;

  logic       a_valid, a_ready, a_fill, a_clr, a_q, a_is_ur, a_ws;
  logic [3:0] a_data;
  logic [2:0] a_level;
  logic [1:0] a_cnt;

  logic       b_valid, b_ready, b_fill, b_clr, b_q, b_is_ur, b_ws;
  logic [3:0] b_data;
  logic [2:0] b_level;
  logic [7:0] b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk128 = ~clk128;

  spdif_bmc_stream_encoder #(.WIDTH(4), .DEPTH(4), .START_LEVEL(1), .COUNT_WIDTH(2)) dut_a (
    .clk128(clk128), .reset_n(reset_n), .i_valid(a_valid), .i_ready(a_ready),
    .i_data(a_data), .fill_en(a_fill), .count_clear(a_clr), .q(a_q),
    .level(a_level), .is_underrun(a_is_ur), .word_start(a_ws),
    .underrun_count(a_cnt)
  );

  spdif_bmc_stream_encoder #(.WIDTH(4), .DEPTH(4), .START_LEVEL(4), .COUNT_WIDTH(8)) dut_b (
    .clk128(clk128), .reset_n(reset_n), .i_valid(b_valid), .i_ready(b_ready),
    .i_data(b_data), .fill_en(b_fill), .count_clear(b_clr), .q(b_q),
    .level(b_level), .is_underrun(b_is_ur), .word_start(b_ws),
    .underrun_count(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk128);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check_eq({tag, "_q"},     32'(a_q),       32'd0);
    check_eq({tag, "_level"}, 32'(a_level),   32'd0);
    check_eq({tag, "_ready"}, 32'(a_ready),   32'd1);
    check_eq({tag, "_ur"},    32'(a_is_ur),   32'd0);
    check_eq({tag, "_ws"},    32'(a_ws),      32'd0);
    check_eq({tag, "_cnt"},   32'(a_cnt),     32'd0);
  endtask

  // q after edges 2..17 of the single-word / mid-slot scenario (hand derived)
  logic       qa_exp [16] = '{1'b1, 1'b1, 1'b0, 1'b1,   // word 1011
                              1'b0, 1'b0, 1'b1, 1'b1,   // fill slot
                              1'b0, 1'b0, 1'b1, 1'b1,   // fill slot, resume
                              1'b0, 1'b1, 1'b1, 1'b1};  // word 1100
  logic [3:0] tbl [16] = '{4'h9, 4'h3, 4'hE, 4'h5, 4'h0, 4'hF, 4'h6, 4'hA,
                           4'h1, 4'hC, 4'h7, 4'h8, 4'h2, 4'hD, 4'h4, 4'hB};

  initial begin
    int   widx;
    logic acc;
    logic qm;
    int   lvl;
    logic [3:0] w;

    reset_n = 1'b0;
    a_valid = 1'b0; a_data = 4'h0; a_fill = 1'b1; a_clr = 1'b0;
    b_valid = 1'b0; b_data = 4'h0; b_fill = 1'b1; b_clr = 1'b0;
    tick();
    tick();
    check_a_reset("rst");
    check_eq("rst_b_ready", 32'(b_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    check_eq("idle_a_ws", 32'(a_ws), 32'd0);
    check_eq("idle_a_q",  32'(a_q),  32'd0);

    // ---------------- back-to-back on dut_b (START_LEVEL=4) ----------------
    widx = 0;
    qm   = 1'b0;
    b_valid = 1'b1;
    b_data  = tbl[0];
    for (int c = 0; c < 40; c++) begin
      acc = b_ready;
      tick();
      if (acc) widx++;
      b_data = tbl[widx % 16];
      lvl = (c <= 3) ? c + 1 : (((c - 4) % 4 == 0) ? 3 : 4);
      if (c >= 5) begin
        w  = tbl[(c - 5) / 4];
        qm = qm ^ w[3 - ((c - 5) % 4)];
      end
      check_eq($sformatf("b_level@%0d", c), 32'(b_level), 32'(lvl));
      check_eq($sformatf("b_ready@%0d", c), 32'(b_ready), 32'(lvl != 4));
      check_eq($sformatf("b_ws@%0d", c),    32'(b_ws),    32'(c >= 4 && ((c - 4) % 4 == 0)));
      check_eq($sformatf("b_ur@%0d", c),    32'(b_is_ur), 32'd0);
      check_eq($sformatf("b_q@%0d", c),     32'(b_q),     32'(qm));
    end
    b_valid = 1'b0;

    // ---------------- single word, fill underrun, mid-slot resume on dut_a ----
    a_valid = 1'b1;
    a_data  = 4'b1011;
    tick();                                     // edge 0: write
    a_valid = 1'b0;
    check_eq("a_lvl@0", 32'(a_level), 32'd1);
    check_eq("a_ws@0",  32'(a_ws),    32'd0);
    tick();                                     // edge 1: pop
    check_eq("a_ws@1",  32'(a_ws),    32'd1);
    check_eq("a_lvl@1", 32'(a_level), 32'd0);
    check_eq("a_q@1",   32'(a_q),     32'd0);
    for (int e = 2; e <= 17; e++) begin
      if (e == 11) begin
        a_valid = 1'b1;
        a_data  = 4'b1100;
      end
      tick();
      a_valid = 1'b0;
      check_eq($sformatf("a_q@%0d", e), 32'(a_q), 32'(qa_exp[e - 2]));
      if (e == 5) begin
        check_eq("a_ur@5",  32'(a_is_ur), 32'd1);
        check_eq("a_cnt@5", 32'(a_cnt),   32'd1);
      end
      if (e == 9)  check_eq("a_cnt@9",  32'(a_cnt),   32'd2);
      if (e == 11) check_eq("a_lvl@11", 32'(a_level), 32'd1);
      if (e == 12) begin
        check_eq("a_ws@12",  32'(a_ws),    32'd0);
        check_eq("a_ur@12",  32'(a_is_ur), 32'd1);
        check_eq("a_lvl@12", 32'(a_level), 32'd1);
      end
      if (e == 13) begin
        check_eq("a_ws@13",  32'(a_ws),    32'd1);
        check_eq("a_ur@13",  32'(a_is_ur), 32'd0);
        check_eq("a_lvl@13", 32'(a_level), 32'd0);
        check_eq("a_cnt@13", 32'(a_cnt),   32'd2);
      end
      if (e == 17) begin
        check_eq("a_ur@17",  32'(a_is_ur), 32'd1);
        check_eq("a_cnt@17", 32'(a_cnt),   32'd3);
      end
    end

    // ---------------- hold-mode underrun, saturation and clear ----------------
    a_fill = 1'b0;
    a_clr  = 1'b1;
    tick();                                     // edge 18: clear on non-increment edge
    a_clr = 1'b0;
    check_eq("a_cnt@18", 32'(a_cnt), 32'd0);
    check_eq("a_q@18",   32'(a_q),   32'd1);
    for (int e = 19; e <= 45; e++) begin
      if (e == 41) a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      if (e <= 37) check_eq($sformatf("a_hold_q@%0d", e), 32'(a_q), 32'd1);
      if (e == 21) check_eq("a_cnt@21", 32'(a_cnt), 32'd1);
      if (e == 25) check_eq("a_cnt@25", 32'(a_cnt), 32'd2);
      if (e == 29) check_eq("a_cnt@29", 32'(a_cnt), 32'd3);
      if (e == 33) check_eq("a_cnt_sat@33", 32'(a_cnt), 32'd3);
      if (e == 37) begin
        check_eq("a_cnt_sat@37", 32'(a_cnt),   32'd3);
        check_eq("a_ur@37",      32'(a_is_ur), 32'd1);
      end
      if (e == 41) check_eq("a_clr_wins@41", 32'(a_cnt), 32'd0);
      if (e == 45) check_eq("a_cnt@45",      32'(a_cnt), 32'd1);
    end

    // ---------------- reset mid-word ----------------
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_a_reset("rst2");
    a_fill  = 1'b1;
    a_valid = 1'b1;
    a_data  = 4'b1000;
    tick();                                     // r0: write
    a_data = 4'b0101;
    tick();                                     // r1: pop + write
    check_eq("mr_ws@1", 32'(a_ws), 32'd1);
    tick();                                     // r2
    check_eq("mr_q@2", 32'(a_q), 32'd1);
    tick();                                     // r3: bit_cnt=2, level=3
    a_valid = 1'b0;
    check_eq("mr_lvl@3",   32'(a_level), 32'd3);
    check_eq("mr_q@3",     32'(a_q),     32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_a_reset("mr_rst");
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("mr_idle_ws@%0d", k), 32'(a_ws), 32'd0);
      check_eq($sformatf("mr_idle_q@%0d", k),  32'(a_q),  32'd0);
    end
    check_eq("mr_idle_cnt", 32'(a_cnt),   32'd0);
    check_eq("mr_idle_ur",  32'(a_is_ur), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spdif_bmc_stream_encoder.md
# spdif_bmc_stream_encoder

Parametrised successor to the S/PDIF transition-bit serialiser. It accepts WIDTH-bit words of pre-computed transition bits, buffers them in a DEPTH-entry FIFO, and shifts them MSB-first onto the line, toggling q on each '1' bit. New behaviours:
- Configurable prefill threshold before the first word is sent.
- Word-aligned underrun handling with an optional BMC-zero fill pattern.
- A saturating underrun counter.

It sits between the frame/subframe builder and the S/PDIF output pin, clocked at 128×fs.

## Interface
- WIDTH, 4: bits per input word, power of two, ≥2
- DEPTH, 4: FIFO entries, power of two, ≥2
- START_LEVEL, 1: words that must be buffered before leaving IDLE; range 1..DEPTH
- COUNT_WIDTH, 8: width of underrun_count
- clk128  in  1: bit-cell (half-cell) clock; all logic on rising edge
- reset_n  in  1: synchronous, active-low reset
- i_valid  in  1: i_data valid
- i_ready  out  1: FIFO can accept a word
- i_data  in  WIDTH: transition bits, MSB sent first
- fill_en  in  1: during underrun, 1 = emit BMC-zero fill, 0 = hold q
- count_clear  in  1: synchronous clear of underrun_count
- q  out  1: line output
- level  out  $clog2(DEPTH+1): FIFO occupancy
- is_underrun  out  1: high while in UNDERRUN
- word_start  out  1: one-cycle pulse on each FIFO pop into the shifter
- underrun_count  out  COUNT_WIDTH: saturating count of empty word slots

## Operation
- **Write:** a word is written on every edge with i_valid && i_ready. i_ready = (level < DEPTH), combinational from registered level.
- **Pop:** uses the level sampled before the edge. A word written on edge N is first poppable at edge N+1. A simultaneous write and pop leaves level unchanged.
- **States:**
  - IDLE: q holds. At an edge with level ≥ START_LEVEL: pop into the shifter, bit_cnt=0, word_start=1, go to RUN.
  - RUN: each edge, q <= q ^ shift[WIDTH-1], shift <<= 1, bit_cnt++ (wraps mod WIDTH). At the edge with bit_cnt==WIDTH-1 (last bit):
    - level>0: pop, word_start=1, stay in RUN with no gap.
    - otherwise: go to UNDERRUN and increment underrun_count.
  - UNDERRUN: bit_cnt keeps cycling. Each edge, q <= q ^ (fill_en & ~bit_cnt[0]), giving the pattern 1,0,1,0… (a BMC zero cell). At the edge with bit_cnt==WIDTH-1:
    - level>0: pop, word_start=1, go to RUN.
    - otherwise: stay in UNDERRUN and increment underrun_count.
- Resume happens only at a slot boundary; mid-slot writes never shorten the fill.
- IDLE never counts underruns. The counter runs only after the first word has been sent.
- **underrun_count:** saturates at all-ones. count_clear sets it to 0 and wins over a simultaneous increment.
- **is_underrun:** registered; equals (state==UNDERRUN).

## Timing
- **Reset** (reset_n low at an edge) sets: q=0, state=IDLE, bit_cnt=0, shift=0, FIFO empty, level=0, i_ready=1, is_underrun=0, word_start=0, underrun_count=0.
- Reset mid-word discards the shifter and FIFO contents.
- **Latency**, START_LEVEL=1: write at edge N → pop at edge N+1 → the first q update (MSB) is at edge N+2. The last bit of that word is at edge N+1+WIDTH.
- Throughput: one word per WIDTH cycles, with no bubble while level>0 at each boundary.
- **Full:** at level=DEPTH, i_ready=0. A write is accepted in the same cycle as a pop only if level<DEPTH before the edge; no bypass.

## Test plan
All scenarios use WIDTH=4, DEPTH=4.
- **Single word then underrun** (START_LEVEL=1, fill_en=1, q=0): write 4'b1011 at edge 0.
  - Edges 2..5: q=1,1,0,1.
  - Edge 5: is_underrun=1, underrun_count=1.
  - Edges 6..9: q=0,0,1,1.
  - Edge 9: underrun_count=2.
- **Back-to-back:** hold i_valid with random data for 40 cycles, START_LEVEL=4.
  - First pop only after level=4.
  - word_start every 4 cycles, is_underrun stays 0.
  - i_ready drops whenever level=4.
  - q matches the reference model.
- **Hold-mode underrun:** fill_en=0, FIFO drains. q is constant through 3 empty slots, then underrun_count=3.
- **Mid-slot resume:** in UNDERRUN, write a word at bit_cnt=1.
  - No pop until the edge with bit_cnt==3; word_start pulses then.
  - The word's MSB appears on the following edge; is_underrun falls at the pop edge.
- **Saturation/clear** (COUNT_WIDTH=2): 5 empty slots → count stays 3. count_clear asserted on an increment edge → 0.
- **Reset mid-word:** reset_n low at bit_cnt=2 with level=3 → next edge q=0, level=0, i_ready=1, state IDLE.
